// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
package mem_arb_pkg;

   localparam int unsigned DEFAULT_ADDR_W = 64;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} arb_state_t;
   typedef enum logic {OWN_IF, OWN_D} owner_t;

endpackage

// File: rtl/instr_lane_select.sv
// Picks one 32-bit lane of a 64-bit memory word using byte-address bit 2.
module instr_lane_select (
   input  logic [63:0] word,
   input  logic        sel_hi,
   output logic [31:0] instr
);

   assign instr = sel_hi ? word[63:32] : word[31:0];

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one fixed-latency 64-bit memory port between instruction fetch and data access.
module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned MAX_STREAK = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [31:0]       if_rdata,
   output logic              if_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [63:0]       d_wdata,
   output logic              d_ack,
   output logic [63:0]       d_rdata,
   output logic              d_err,
   output logic [ADDR_W-1:0] mem_raddress,
   output logic [ADDR_W-1:0] mem_waddress,
   output logic [63:0]       mem_wdata,
   output logic              mem_wr,
   input  logic [63:0]       mem_rdata,
   output logic              busy
);

   localparam int unsigned CNT_W    = $clog2(MEM_LAT + 1);
   localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);

   arb_state_t          state_q, state_d;
   owner_t              owner_q, owner_d;
   logic [ADDR_W-1:2]   addr_q, addr_d;
   logic [63:0]         wdata_q, wdata_d;
   logic                we_q, we_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic [31:0]         if_rdata_q, if_rdata_d;
   logic [63:0]         d_rdata_q, d_rdata_d;
   logic                if_err_q, if_err_d;
   logic                d_err_q, d_err_d;

   logic        streak_full, grant_d, grant_if, in_wait;
   logic [31:0] lane;

   instr_lane_select u_lane (
      .word   (mem_rdata),
      .sel_hi (addr_q[2]),
      .instr  (lane)
   );

   // D normally wins; IF is forced through once D has won MAX_STREAK times in a row.
   assign streak_full = (streak_q == STREAK_W'(MAX_STREAK));
   assign grant_d     = d_req && !(if_req && streak_full);
   assign grant_if    = if_req && !grant_d;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      cnt_d      = cnt_q;
      streak_d   = streak_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      if_err_d   = if_err_q;
      d_err_d    = d_err_q;
      unique case (state_q)
         IDLE: begin
            if (grant_d) begin
               owner_d  = OWN_D;
               addr_d   = d_addr[ADDR_W-1:2];
               wdata_d  = d_wdata;
               we_d     = d_we;
               cnt_d    = CNT_W'(MEM_LAT);
               // Cannot overflow: D is refused at saturation while IF waits.
               streak_d = if_req ? streak_q + STREAK_W'(1) : '0;
               if (d_addr[2:0] != 3'b000) begin
                  d_err_d = 1'b1;
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
               end
            end else if (grant_if) begin
               owner_d  = OWN_IF;
               addr_d   = if_addr[ADDR_W-1:2];
               wdata_d  = '0;
               we_d     = 1'b0;
               cnt_d    = CNT_W'(MEM_LAT);
               streak_d = '0;
               if (if_addr[1:0] != 2'b00) begin
                  if_err_d = 1'b1;
                  state_d  = RESP;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               if (owner_q == OWN_D) begin
                  d_rdata_d = mem_rdata;
                  d_err_d   = 1'b0;
               end else begin
                  if_rdata_d = lane;
                  if_err_d   = 1'b0;
               end
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         owner_q    <= OWN_IF;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         cnt_q      <= '0;
         streak_q   <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         if_err_q   <= 1'b0;
         d_err_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         cnt_q      <= cnt_d;
         streak_q   <= streak_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         if_err_q   <= if_err_d;
         d_err_q    <= d_err_d;
      end
   end

   assign in_wait      = (state_q == WAIT);
   assign mem_raddress = in_wait ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
   assign mem_waddress = in_wait ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
   assign mem_wdata    = in_wait ? wdata_q : '0;
   // The counter still holds MEM_LAT only in the first WAIT cycle.
   assign mem_wr       = in_wait && (owner_q == OWN_D) && we_q && (cnt_q == CNT_W'(MEM_LAT));
   assign if_ack       = (state_q == RESP) && (owner_q == OWN_IF);
   assign d_ack        = (state_q == RESP) && (owner_q == OWN_D);
   assign if_rdata     = if_rdata_q;
   assign d_rdata      = d_rdata_q;
   assign if_err       = if_err_q;
   assign d_err        = d_err_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: one arbiter with MEM_LAT=1 and one with MEM_LAT=3 on a shared memory model.
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset, preload, sel;
   logic        if_req, d_req, d_we;
   logic [63:0] if_addr, d_addr, d_wdata;

   logic        if_ack1, if_err1, d_ack1, d_err1, mem_wr1, busy1;
   logic [31:0] if_rdata1;
   logic [63:0] d_rdata1, mem_raddress1, mem_waddress1, mem_wdata1, mem_rdata1;
   logic        if_ack3, if_err3, d_ack3, d_err3, mem_wr3, busy3;
   logic [31:0] if_rdata3;
   logic [63:0] d_rdata3, mem_raddress3, mem_waddress3, mem_wdata3, mem_rdata3;

   logic        o_if_ack, o_if_err, o_d_ack, o_d_err, o_mem_wr, o_busy;
   logic [31:0] o_if_rdata;
   logic [63:0] o_d_rdata;

   logic [63:0] mem [0:31];
   int          n_assert = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   unified_mem_arbiter #(.ADDR_W(64), .MEM_LAT(1), .MAX_STREAK(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack1), .if_rdata(if_rdata1),
      .if_err(if_err1), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack1), .d_rdata(d_rdata1), .d_err(d_err1), .mem_raddress(mem_raddress1),
      .mem_waddress(mem_waddress1), .mem_wdata(mem_wdata1), .mem_wr(mem_wr1),
      .mem_rdata(mem_rdata1), .busy(busy1)
   );

   unified_mem_arbiter #(.ADDR_W(64), .MEM_LAT(3), .MAX_STREAK(4)) dut3 (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack3), .if_rdata(if_rdata3),
      .if_err(if_err3), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack3), .d_rdata(d_rdata3), .d_err(d_err3), .mem_raddress(mem_raddress3),
      .mem_waddress(mem_waddress3), .mem_wdata(mem_wdata3), .mem_wr(mem_wr3),
      .mem_rdata(mem_rdata3), .busy(busy3)
   );

   assign o_if_ack   = sel ? if_ack3   : if_ack1;
   assign o_if_err   = sel ? if_err3   : if_err1;
   assign o_if_rdata = sel ? if_rdata3 : if_rdata1;
   assign o_d_ack    = sel ? d_ack3    : d_ack1;
   assign o_d_err    = sel ? d_err3    : d_err1;
   assign o_d_rdata  = sel ? d_rdata3  : d_rdata1;
   assign o_mem_wr   = sel ? mem_wr3   : mem_wr1;
   assign o_busy     = sel ? busy3     : busy1;

   always @(posedge clk) begin
      if (preload) begin
         mem[0] <= 64'hAABBCCDD_11223344;
         mem[1] <= 64'h55667788_99AABBCC;
         mem[8] <= 64'h01234567_89ABCDEF;
      end else begin
         if (mem_wr1) mem[mem_waddress1[7:3]] <= mem_wdata1;
         if (mem_wr3) mem[mem_waddress3[7:3]] <= mem_wdata3;
      end
   end
   assign mem_rdata1 = mem[mem_raddress1[7:3]];
   assign mem_rdata3 = mem[mem_raddress3[7:3]];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one request and waits (bounded) for its ack; returns ack latency in edges.
   task automatic xact(input logic is_d, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, output int lat, output int wr,
                       output int other, output logic err, output logic [63:0] ra);
      logic done;
      lat = 0; wr = 0; other = 0; err = 1'b0; ra = '0; done = 1'b0;
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      while (!done && lat < 20) begin
         tick();
         lat++;
         if (lat == 1) ra = sel ? mem_raddress3 : mem_raddress1;
         if (o_mem_wr) wr++;
         if (is_d ? o_d_ack : o_if_ack) begin
            done = 1'b1;
            err  = is_d ? o_d_err : o_if_err;
         end else if (is_d ? o_if_ack : o_d_ack) begin
            other++;
         end
      end
      d_req  = 1'b0;
      if_req = 1'b0;
      check("ack_timeout", 64'(done), 64'd1);
      tick();
   endtask

   initial begin
      int          lat, wr, other, cnt, w;
      logic        err;
      logic [63:0] ra;
      logic [5:0]  order;

      reset = 1'b1; preload = 1'b1; sel = 1'b0;
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      #2 reset = 1'b0;
      #1;
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_if_ack", 64'(o_if_ack), 64'd0);
      check("rst_d_ack", 64'(o_d_ack), 64'd0);
      check("rst_mem_wr", 64'(o_mem_wr), 64'd0);
      check("rst_raddr", mem_raddress1, 64'd0);
      check("rst_if_rdata", 64'(o_if_rdata), 64'd0);
      check("rst_d_rdata", o_d_rdata, 64'd0);
      check("rst_errs", {62'd0, o_if_err, o_d_err}, 64'd0);
      @(posedge clk);
      @(posedge clk);
      #2 preload = 1'b0;
      #5 reset = 1'b1;
      tick();

      // Reset during the write cycle of a store abandons it.
      d_req = 1'b1; d_we = 1'b1; d_addr = 64'h10; d_wdata = 64'h1111_2222_3333_4444;
      tick();
      check("t1_wr_inflight", 64'(o_mem_wr), 64'd1);
      #2 reset = 1'b0;
      #1;
      check("t1_wr_reset", 64'(o_mem_wr), 64'd0);
      check("t1_busy_reset", 64'(o_busy), 64'd0);
      d_req = 1'b0; d_we = 1'b0;
      #1 reset = 1'b1;
      cnt = 0;
      repeat (6) begin
         tick();
         if (o_d_ack) cnt++;
      end
      check("t1_no_ack", 64'(cnt), 64'd0);

      xact(1'b0, 1'b0, 64'h4, 64'd0, lat, wr, other, err, ra);
      check("t2_lat", 64'(lat), 64'd2);
      check("t2_raddr", ra, 64'h0);
      check("t2_err", 64'(err), 64'd0);
      check("t2_rdata", 64'(o_if_rdata), 64'hAABBCCDD);
      check("t2_no_d_ack", 64'(other), 64'd0);

      xact(1'b1, 1'b1, 64'h20, 64'hDEADBEEF_CAFEF00D, lat, wr, other, err, ra);
      check("t3_st_lat", 64'(lat), 64'd2);
      check("t3_st_wr_cycles", 64'(wr), 64'd1);
      check("t3_st_err", 64'(err), 64'd0);
      check("t3_mem", mem[4], 64'hDEADBEEF_CAFEF00D);
      xact(1'b1, 1'b0, 64'h20, 64'd0, lat, wr, other, err, ra);
      check("t3_ld_lat", 64'(lat), 64'd2);
      check("t3_ld_wr_cycles", 64'(wr), 64'd0);
      check("t3_ld_rdata", o_d_rdata, 64'hDEADBEEF_CAFEF00D);

      // Both held: four D grants, then IF is forced, then D again.
      if_req = 1'b1; if_addr = 64'h8;
      d_req = 1'b1; d_we = 1'b0; d_addr = 64'h20;
      for (int t = 0; t < 6; t++) begin
         w = 0;
         do begin
            tick();
            w++;
         end while (!(o_if_ack || o_d_ack) && w < 10);
         order[t] = o_if_ack ? 1'b1 : (o_d_ack ? 1'b0 : 1'bx);
         if (o_if_ack) if_req = 1'b0;
      end
      d_req = 1'b0;
      tick();
      tick();
      check("t4_order", 64'(order), 64'b010000);
      check("t4_if_rdata", 64'(o_if_rdata), 64'h99AABBCC);
      check("t4_idle", 64'(o_busy), 64'd0);

      xact(1'b1, 1'b1, 64'h13, 64'hFFFF, lat, wr, other, err, ra);
      check("t5_d_lat", 64'(lat), 64'd1);
      check("t5_d_err", 64'(err), 64'd1);
      check("t5_d_wr", 64'(wr), 64'd0);
      check("t5_d_rdata_kept", o_d_rdata, 64'hDEADBEEF_CAFEF00D);
      xact(1'b0, 1'b0, 64'h6, 64'd0, lat, wr, other, err, ra);
      check("t5_if_lat", 64'(lat), 64'd1);
      check("t5_if_err", 64'(err), 64'd1);
      check("t5_if_rdata_kept", 64'(o_if_rdata), 64'h99AABBCC);
      check("t5_d_err_kept", 64'(o_d_err), 64'd1);

      #2 reset = 1'b0;
      #1 reset = 1'b1;
      sel = 1'b1;
      xact(1'b1, 1'b0, 64'h40, 64'd0, lat, wr, other, err, ra);
      check("t6_lat", 64'(lat), 64'd4);
      check("t6_raddr", ra, 64'h40);
      check("t6_err", 64'(err), 64'd0);
      check("t6_rdata", o_d_rdata, 64'h01234567_89ABCDEF);
      check("t6_no_if_ack", 64'(other), 64'd0);
      check("t6_if_rdata", 64'(o_if_rdata), 64'd0);
      check("t6_wr", 64'(wr), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
